// File: rtl/ntt_bf_sched.sv
// Butterfly address/control sequencer for the Dilithium NTT/INTT (N = 2^LOGN).
// Walks all LOGN stages and issues one coefficient pair per cycle. It also
// issues twiddle addresses, the butterfly mode aligned with the RAM read
// data, and write-back strobes delayed by the read + butterfly latency.
// Optional build macro: NTT_BF_SCHED_STALL_EN adds a 'stall' input that
// freezes issue while the write-back delay line keeps retiring.
//
// Handshake: start is a one-cycle request honoured only in IDLE. rd_en and
// wr_en are single-cycle strobes with no back-pressure; their address outputs
// are meaningful only in cycles where the strobe is high.
module ntt_bf_sched #(
    parameter int LOGN       = 8,
    parameter int RAM_RD_LAT = 1,
    parameter int BF_LAT     = 6
) (
    input  logic            clk,
    input  logic            rst,
`ifdef NTT_BF_SCHED_STALL_EN
    input  logic            stall,
`endif
    input  logic            start,
    input  logic            op,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic [1:0]      bf_mode,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int DRAIN = RAM_RD_LAT + BF_LAT;
    localparam int PW    = LOGN - 1;
    localparam int SW    = $clog2(LOGN);
    localparam int DW    = $clog2(DRAIN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [PW-1:0]   pair_q, pair_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [LOGN-1:0] k_q, k_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic [DRAIN-1:0] ren_sr_q, ren_sr_d;
    logic [LOGN-1:0]  wa_sr_q [DRAIN];
    logic [LOGN-1:0]  wa_sr_d [DRAIN];
    logic [LOGN-1:0]  wb_sr_q [DRAIN];
    logic [LOGN-1:0]  wb_sr_d [DRAIN];

    logic            stall_w;
    logic            rd_en_w;
    logic [SW-1:0]   lvl_w;
    logic [LOGN-1:0] len_w;
    logic [LOGN-1:0] mask_w;
    logic [LOGN-1:0] p_ext_w;
    logic [LOGN-1:0] j_w;
    logic            grp_end_w;

`ifdef NTT_BF_SCHED_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // Stage geometry: forward walks len from N/2 down to 1, inverse walks up.
    // j inserts a zero at bit 'lvl' of the pair index; the partner is j | len.
    assign lvl_w     = op_q ? stage_q : (SW'(LOGN - 1) - stage_q);
    assign len_w     = LOGN'(1) << lvl_w;
    assign mask_w    = len_w - LOGN'(1);
    assign p_ext_w   = {1'b0, pair_q};
    assign j_w       = (((p_ext_w >> lvl_w) << 1) << lvl_w) | (p_ext_w & mask_w);
    assign grp_end_w = ((p_ext_w & mask_w) == mask_w);
    assign rd_en_w   = (state_q == S_RUN) && !stall_w;

    // Next-state and counter update for the stage walker.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pair_d  = pair_q;
        stage_d = stage_q;
        k_d     = k_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    pair_d  = '0;
                    stage_d = '0;
                    k_d     = op ? {LOGN{1'b1}} : LOGN'(1);
                    drain_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall_w) begin
                    pair_d = pair_q + PW'(1);
                    if (grp_end_w) begin
                        k_d = op_q ? (k_q - LOGN'(1)) : (k_q + LOGN'(1));
                    end
                    if (pair_q == {PW{1'b1}}) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!stall_w) begin
                    if (drain_q == DW'(DRAIN - 1)) begin
                        drain_d = '0;
                        if (stage_q == SW'(LOGN - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            stage_d = stage_q + SW'(1);
                            state_d = S_RUN;
                        end
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write-back delay line: read strobe and addresses shifted DRAIN cycles.
    always_comb begin
        ren_sr_d   = {ren_sr_q[DRAIN-2:0], rd_en_w};
        wa_sr_d[0] = rd_addr_a;
        wb_sr_d[0] = rd_addr_b;
        for (int i = 1; i < DRAIN; i++) begin
            wa_sr_d[i] = wa_sr_q[i-1];
            wb_sr_d[i] = wb_sr_q[i-1];
        end
    end

    // State and delay-line registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            pair_q   <= '0;
            stage_q  <= '0;
            k_q      <= '0;
            drain_q  <= '0;
            ren_sr_q <= '0;
            for (int i = 0; i < DRAIN; i++) begin
                wa_sr_q[i] <= '0;
                wb_sr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pair_q   <= pair_d;
            stage_q  <= stage_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            ren_sr_q <= ren_sr_d;
            for (int i = 0; i < DRAIN; i++) begin
                wa_sr_q[i] <= wa_sr_d[i];
                wb_sr_q[i] <= wb_sr_d[i];
            end
        end
    end

    // Addresses are forced to zero outside issue cycles so idle outputs are quiet.
    assign rd_en     = rd_en_w;
    assign rd_addr_a = rd_en_w ? j_w : '0;
    assign rd_addr_b = rd_en_w ? (j_w | len_w) : '0;
    assign tw_addr   = rd_en_w ? k_q : '0;
    assign bf_mode   = ren_sr_q[RAM_RD_LAT-1] ? {1'b0, op_q} : 2'b11;
    assign wr_en     = ren_sr_q[DRAIN-1];
    assign wr_addr_a = wa_sr_q[DRAIN-1];
    assign wr_addr_b = wb_sr_q[DRAIN-1];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Self-checking bench for ntt_bf_sched: a per-cycle reference schedule is built
// from the transform's loop nest and timing rules and compared against the DUT.
module tb_ntt_bf_sched;

    localparam int DRAIN = 7;
    localparam int MAXC  = 1120;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op;
`ifdef NTT_BF_SCHED_STALL_EN
    logic       stall;
`endif
    logic       busy, done, rd_en, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
    logic [1:0] bf_mode;

    ntt_bf_sched dut (
        .clk       (clk),
        .rst       (rst),
`ifdef NTT_BF_SCHED_STALL_EN
        .stall     (stall),
`endif
        .start     (start),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_mode   (bf_mode),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    // Clock
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected pair stream {a, b, tw} in issue order.
    logic [23:0] exp_q[$];

    logic       e_rd [MAXC], e_wr [MAXC], e_busy [MAXC], e_done [MAXC];
    logic [7:0] e_a [MAXC], e_b [MAXC], e_tw [MAXC], e_wa [MAXC], e_wb [MAXC];
    logic [1:0] e_bf [MAXC];

    logic       o_rd [MAXC], o_wr [MAXC], o_busy [MAXC], o_done [MAXC];
    logic [7:0] o_a [MAXC], o_b [MAXC], o_tw [MAXC], o_wa [MAXC], o_wb [MAXC];
    logic [1:0] o_bf [MAXC];

    // Transform loop nest straight from the algorithm definition.
    task automatic build_pairs(input logic op_i);
        int k;
        exp_q.delete();
        if (!op_i) begin
            k = 1;
            for (int len = 128; len >= 1; len = len / 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++)
                        exp_q.push_back({8'(j), 8'(j + len), 8'(k)});
                    k++;
                end
        end else begin
            k = 255;
            for (int len = 1; len <= 128; len = len * 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++)
                        exp_q.push_back({8'(j), 8'(j + len), 8'(k)});
                    k--;
                end
        end
    endtask

    // Per-cycle schedule: 128 issue slots per stage (skipping stalled cycles),
    // DRAIN idle cycles, then done; writes and mode follow the read slots.
    task automatic build_model(input logic op_i, input int ss, input int sl);
        int c;
        logic [23:0] w;
        build_pairs(op_i);
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
            e_bf[i] = 2'b11;
        end
        c = 1;
        for (int s = 0; s < 8; s++) begin
            int issued = 0;
            while (issued < 128) begin
                if (!(c >= ss && c < ss + sl)) begin
                    w = exp_q.pop_front();
                    e_rd[c] = 1;
                    e_a[c] = w[23:16]; e_b[c] = w[15:8]; e_tw[c] = w[7:0];
                    issued++;
                end
                c++;
            end
            c += DRAIN;
        end
        e_done[c] = 1;
        for (int i = 1; i <= c; i++) e_busy[i] = 1;
        for (int i = 1; i < MAXC - DRAIN; i++) begin
            if (e_rd[i]) begin
                e_bf[i+1] = {1'b0, op_i};
                e_wr[i+DRAIN] = 1;
                e_wa[i+DRAIN] = e_a[i];
                e_wb[i+DRAIN] = e_b[i];
            end
        end
    endtask

    // Driver: start a transform and record every cycle's outputs.
    task automatic do_run(input logic op_i, input bit perturb, input int ss, input int sl);
        op = op_i;
        start = 1'b1;
`ifdef NTT_BF_SCHED_STALL_EN
        stall = (ss == 1);
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < MAXC; c++) begin
            o_rd[c] = rd_en; o_a[c] = rd_addr_a; o_b[c] = rd_addr_b; o_tw[c] = tw_addr;
            o_bf[c] = bf_mode; o_wr[c] = wr_en; o_wa[c] = wr_addr_a; o_wb[c] = wr_addr_b;
            o_busy[c] = busy; o_done[c] = done;
            if (perturb && c < 1070) begin
                start = ($urandom_range(0, 15) == 0);
                op    = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
`ifdef NTT_BF_SCHED_STALL_EN
            stall = (c + 1 >= ss && c + 1 < ss + sl);
`endif
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Scoreboard sweep over the recorded trace: number of cycles disagreeing with the model.
    task automatic trace_diff(output int nmis, output string first);
        nmis = 0;
        first = "none";
        for (int c = 1; c < MAXC; c++) begin
            bit bad;
            bad = (o_rd[c] !== e_rd[c]) || (o_wr[c] !== e_wr[c]) || (o_bf[c] !== e_bf[c]) ||
                  (o_busy[c] !== e_busy[c]) || (o_done[c] !== e_done[c]);
            if (e_rd[c] && (o_a[c] !== e_a[c] || o_b[c] !== e_b[c] || o_tw[c] !== e_tw[c])) bad = 1;
            if (e_wr[c] && (o_wa[c] !== e_wa[c] || o_wb[c] !== e_wb[c])) bad = 1;
            if (bad) begin
                if (nmis == 0)
                    first = $sformatf("cycle %0d rd=%b a=%0d b=%0d tw=%0d bf=%b wr=%b wa=%0d wb=%0d busy=%b done=%b exp rd=%b a=%0d b=%0d tw=%0d bf=%b wr=%b wa=%0d wb=%0d busy=%b done=%b",
                        c, o_rd[c], o_a[c], o_b[c], o_tw[c], o_bf[c], o_wr[c], o_wa[c], o_wb[c], o_busy[c], o_done[c],
                        e_rd[c], e_a[c], e_b[c], e_tw[c], e_bf[c], e_wr[c], e_wa[c], e_wb[c], e_busy[c], e_done[c]);
                nmis++;
            end
        end
    endtask

    function automatic int first_done();
        for (int c = 1; c < MAXC; c++) if (o_done[c] === 1'b1) return c;
        return -1;
    endfunction

    function automatic int wr_count();
        int n = 0;
        for (int c = 1; c < MAXC; c++) if (o_wr[c] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0;
`ifdef NTT_BF_SCHED_STALL_EN
        stall = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({rd_en, wr_en, busy, done} !== 4'b0000) begin
            fails++; $display("FAIL reset_strobes got %b expected 0000", {rd_en, wr_en, busy, done});
        end
        tests++;
        if ({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 40'd0) begin
            fails++; $display("FAIL reset_addrs got %h expected 0", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
        end
        tests++;
        if (bf_mode !== 2'b11) begin
            fails++; $display("FAIL reset_bf_mode got %b expected 11", bf_mode);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ntt();
        int nmis, wc, dc, fw;
        string first;
        build_model(1'b0, 0, 0);
        do_run(1'b0, 1'b0, 0, 0);
        tests++;
        if ({o_rd[1], o_a[1], o_b[1], o_tw[1]} !== {1'b1, 8'd0, 8'd128, 8'd1}) begin
            fails++; $display("FAIL ntt_first_pair got rd=%b a=%0d b=%0d tw=%0d expected 1 0 128 1", o_rd[1], o_a[1], o_b[1], o_tw[1]);
        end
        tests++;
        if ({o_a[128], o_b[128], o_rd[129]} !== {8'd127, 8'd255, 1'b0}) begin
            fails++; $display("FAIL ntt_stage1_last got a=%0d b=%0d next_rd=%b expected 127 255 0", o_a[128], o_b[128], o_rd[129]);
        end
        fw = -1;
        for (int c = MAXC - 1; c >= 1; c--) if (o_wr[c] === 1'b1) fw = c;
        tests++;
        if (fw !== 8 || o_wa[8] !== 8'd0 || o_wb[8] !== 8'd128) begin
            fails++; $display("FAIL ntt_first_write got cycle=%0d wa=%0d wb=%0d expected 8 0 128", fw, o_wa[8], o_wb[8]);
        end
        tests++;
        if ({o_rd[135], o_rd[136], o_a[136], o_b[136], o_tw[136]} !== {1'b0, 1'b1, 8'd0, 8'd64, 8'd2}) begin
            fails++; $display("FAIL ntt_stage2_first got rd135=%b rd136=%b a=%0d b=%0d tw=%0d expected 0 1 0 64 2", o_rd[135], o_rd[136], o_a[136], o_b[136], o_tw[136]);
        end
        tests++;
        if ({o_a[200], o_b[200], o_tw[200]} !== {8'd128, 8'd192, 8'd3}) begin
            fails++; $display("FAIL ntt_stage2_pair64 got a=%0d b=%0d tw=%0d expected 128 192 3", o_a[200], o_b[200], o_tw[200]);
        end
        dc = first_done();
        tests++;
        if (dc !== 1081) begin
            fails++; $display("FAIL ntt_done_cycle got %0d expected 1081", dc);
        end
        wc = wr_count();
        tests++;
        if (wc !== 1024) begin
            fails++; $display("FAIL ntt_wr_count got %0d expected 1024", wc);
        end
        trace_diff(nmis, first);
        tests++;
        if (nmis !== 0) begin
            fails++; $display("FAIL ntt_trace got %0d bad cycles expected 0, first: %s", nmis, first);
        end
    endtask

    task automatic test_intt();
        int nmis, wc, dc;
        string first;
        build_model(1'b1, 0, 0);
        do_run(1'b1, 1'b0, 0, 0);
        tests++;
        if ({o_a[1], o_b[1], o_tw[1], o_a[2], o_b[2], o_tw[2]} !== {8'd0, 8'd1, 8'd255, 8'd2, 8'd3, 8'd254}) begin
            fails++; $display("FAIL intt_first_pairs got (%0d,%0d,%0d) (%0d,%0d,%0d) expected (0,1,255) (2,3,254)", o_a[1], o_b[1], o_tw[1], o_a[2], o_b[2], o_tw[2]);
        end
        tests++;
        if ({o_rd[946], o_a[946], o_b[946], o_tw[946]} !== {1'b1, 8'd0, 8'd128, 8'd1}) begin
            fails++; $display("FAIL intt_stage8_first got rd=%b a=%0d b=%0d tw=%0d expected 1 0 128 1", o_rd[946], o_a[946], o_b[946], o_tw[946]);
        end
        tests++;
        if (o_bf[2] !== 2'b01) begin
            fails++; $display("FAIL intt_bf_mode got %b expected 01", o_bf[2]);
        end
        dc = first_done();
        tests++;
        if (dc !== 1081) begin
            fails++; $display("FAIL intt_done_cycle got %0d expected 1081", dc);
        end
        wc = wr_count();
        tests++;
        if (wc !== 1024) begin
            fails++; $display("FAIL intt_wr_count got %0d expected 1024", wc);
        end
        trace_diff(nmis, first);
        tests++;
        if (nmis !== 0) begin
            fails++; $display("FAIL intt_trace got %0d bad cycles expected 0, first: %s", nmis, first);
        end
    endtask

    task automatic test_perturb();
        int nmis, wc;
        string first;
        logic op_i;
        op_i = 1'($urandom_range(0, 1));
        build_model(op_i, 0, 0);
        do_run(op_i, 1'b1, 0, 0);
        wc = wr_count();
        tests++;
        if (wc !== 1024) begin
            fails++; $display("FAIL perturb_wr_count got %0d expected 1024", wc);
        end
        trace_diff(nmis, first);
        tests++;
        if (nmis !== 0) begin
            fails++; $display("FAIL perturb_trace op=%b got %0d bad cycles expected 0, first: %s", op_i, nmis, first);
        end
    endtask

    task automatic test_rst_mid();
        int nmis, nwr;
        string first;
        op = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // advance to cycle 321: stage 3, pair 50
        repeat (320) @(posedge clk);
        #1;
        tests++;
        if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== {1'b1, 8'd82, 8'd114, 8'd5}) begin
            fails++; $display("FAIL rst_mid_prepoint got rd=%b a=%0d b=%0d tw=%0d expected 1 82 114 5", rd_en, rd_addr_a, rd_addr_b, tw_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({rd_en, wr_en, busy, done, bf_mode} !== 6'b000011 ||
            {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 40'd0) begin
            fails++; $display("FAIL rst_mid_outputs got rd=%b wr=%b busy=%b done=%b bf=%b addrs=%h expected 0 0 0 0 11 0",
                rd_en, wr_en, busy, done, bf_mode, {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
        end
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (wr_en !== 1'b0) nwr++;
        end
        tests++;
        if (nwr !== 0) begin
            fails++; $display("FAIL rst_mid_no_wr got %0d write cycles expected 0", nwr);
        end
        build_model(1'b0, 0, 0);
        do_run(1'b0, 1'b0, 0, 0);
        trace_diff(nmis, first);
        tests++;
        if (nmis !== 0) begin
            fails++; $display("FAIL rst_mid_rerun got %0d bad cycles expected 0, first: %s", nmis, first);
        end
    endtask

`ifdef NTT_BF_SCHED_STALL_EN
    task automatic test_stall();
        int nmis, dc, ss, nwr;
        string first;
        ss = $urandom_range(20, 100);
        build_model(1'b0, ss, 5);
        do_run(1'b0, 1'b0, ss, 5);
        dc = first_done();
        tests++;
        if (dc !== 1086) begin
            fails++; $display("FAIL stall_done_cycle got %0d expected 1086", dc);
        end
        nwr = 0;
        for (int c = ss; c < ss + 5; c++) if (o_wr[c] === 1'b1) nwr++;
        tests++;
        if (nwr !== 5) begin
            fails++; $display("FAIL stall_wr_retire got %0d expected 5", nwr);
        end
        trace_diff(nmis, first);
        tests++;
        if (nmis !== 0) begin
            fails++; $display("FAIL stall_trace at=%0d got %0d bad cycles expected 0, first: %s", ss, nmis, first);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ntt();
        test_intt();
        test_perturb();
        test_rst_mid();
`ifdef NTT_BF_SCHED_STALL_EN
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ntt_bf_sched.md
Name: ntt_bf_sched

Overview:
- Address/control sequencer directly upstream of the Dilithium butterfly unit (q = 8380417, N = 256).
- Walks all 8 Cooley-Tukey (NTT) or Gentleman-Sande (INTT) stages and issues coefficient-pair read addresses to a dual-port coefficient RAM plus twiddle-ROM addresses.
- Drives the butterfly mode aligned with the RAM read data.
- Produces delayed write-back enables and addresses matching the butterfly pipeline latency, and inserts drain bubbles so that no stage reads data still in flight.

Parameters:
- LOGN, 8, log2 of the polynomial length; N = 2^LOGN.
- RAM_RD_LAT, 1, cycles from rd_en/rd_addr to RAM data valid at the butterfly a/b/w inputs (1..2).
- BF_LAT, 6, cycles from butterfly a/b/w/mode inputs to valid c/d outputs.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  1  0 = forward NTT, 1 = inverse NTT; latched at start
- busy  out  1  high from the first RUN cycle through the done cycle
- done  out  1  one-cycle pulse when the last write-back has issued
- rd_en  out  1  coefficient RAM read strobe (both ports)
- rd_addr_a  out  LOGN  upper-butterfly coefficient index
- rd_addr_b  out  LOGN  lower-butterfly coefficient index
- tw_addr  out  LOGN  twiddle ROM index
- bf_mode  out  2  butterfly mode: 00 NTT, 01 INTT, 11 idle
- wr_en  out  1  coefficient RAM write strobe (both ports)
- wr_addr_a  out  LOGN  write index for butterfly output c
- wr_addr_b  out  LOGN  write index for butterfly output d

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - All outputs 0, except bf_mode = 2'b11.
  - State IDLE; all delay lines cleared.
  - rst mid-operation aborts immediately; no further wr_en pulses are produced.
- DRAIN = RAM_RD_LAT + BF_LAT (default 7).
- States:
  - IDLE: start=1 latches op, initialises counters, and moves to RUN. Otherwise stays in IDLE.
  - RUN: issues one pair per cycle with rd_en=1, N/2 = 128 pairs per stage. After the last pair of a stage, moves to DRAIN.
  - DRAIN: rd_en=0 for DRAIN cycles. Then either advances the stage and returns to RUN, or, after stage 8, moves to DONE.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Forward NTT (op=0):
  - len = 128, 64, ..., 1; k starts at 1 and increments by 1 per (start, len) group.
  - For each start = 0, 2len, 4len, ...: for j = start .. start+len-1, rd_addr_a = j, rd_addr_b = j+len, tw_addr = k.
- Inverse NTT (op=1):
  - len = 1, 2, ..., 128; k starts at 255 and decrements by 1 per group.
  - Same j/j+len ordering as the forward transform.
  - ROM holds the negated zeta at the INTT indices.
- Address generation: j and k are derived from a LOGN-1-bit pair counter and a stage counter, with no multipliers.
  - Pair p in stage s (len = 2^l): j = ((p >> l) << (l+1)) | (p & (len-1)).
- bf_mode alignment:
  - bf_mode = {1'b0, op} exactly RAM_RD_LAT cycles after each rd_en=1 cycle.
  - Otherwise bf_mode = 2'b11.
- Write-back:
  - rd_en, rd_addr_a and rd_addr_b pass through a DRAIN-deep shift register.
  - wr_en and wr_addr_a/b equal those values delayed by DRAIN cycles.
  - The final stage's writes complete before done.
- Timing: start sampled at edge T0 gives the first RUN cycle at T0+1. done is high in cycle T0+1+8×(128+DRAIN), which is 1081 for defaults.
- Boundary and other rules:
  - start while busy is ignored.
  - op changes while busy are ignored.
  - No RAM address is read in a stage before its last write from the previous stage has issued.
  - No final INTT scaling by N^-1 is applied; that step is external.

Optional Feature:
- NTT_BF_SCHED_STALL_EN: adds an input port stall (1 bit).
  - While stall=1 in RUN, the pair counter, stage counter, k and the RUN/DRAIN state hold, and rd_en=0.
  - In DRAIN, stall pauses the drain counter.
  - The delay lines keep shifting, so in-flight writes still retire.
  - Without the macro there is no stall port and issue proceeds unconditionally.

Test Plan:
- NTT start at T0 → at T0+1: rd_addr_a=0, rd_addr_b=128, tw_addr=1, rd_en=1. At T0+128: a=127, b=255. wr_en first high at T0+8 with wr_addr_a=0, wr_addr_b=128.
- NTT stage 2 → first pair a=0, b=64, tw=2, issued DRAIN=7 cycles after the stage-1 last read. Pair 64: a=128, b=192, tw=3.
- INTT start → first pairs (0,1,tw=255), (2,3,tw=254). Stage 8 first pair (0,128,tw=1). done high at T0+1081. Total wr_en count = 1024.
- start pulse while busy, and op toggled mid-run → sequence, done cycle and wr_en count identical to an unperturbed run.
- rst asserted at RUN pair 50 of stage 3 → next cycle: all outputs at reset values, bf_mode=11, no wr_en for the following 10 cycles. A new start then runs a full 1081-cycle transform.
- With NTT_BF_SCHED_STALL_EN: stall=1 for 5 cycles mid stage 1 → rd_addr sequence has no gaps or repeats, done delayed by exactly 5 cycles, and wr_en continues retiring during the stall.
